sprite_plot_scheduler: RTL and testbench

- Round-robin scheduler that shares the single VGA pixel-plot port (x, y, colour, plot_en) among NUM_REQ 5x5 sprite requesters: pellet, pac-man and ghosts.
- For each granted request it erases the sprite's old 5x5 footprint, draws the new 5x5 shape, then acknowledges.
- Replaces the fixed erase/draw ordering in the game controller with a request/ack service that can take any number of sprites.

---
 rtl/sprite_plot_scheduler.sv | 151 +++++++++++++++
 tb/tb_sprite_plot_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_plot_scheduler.sv
// Round-robin owner of the single pixel-plot port: each granted sprite
// gets its old 5x5 footprint erased, its new shape drawn, then an ack.
module sprite_plot_scheduler #(
  parameter int NUM_REQ = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_erase,
  input  logic [8*NUM_REQ-1:0]   x_old,
  input  logic [7*NUM_REQ-1:0]   y_old,
  input  logic [8*NUM_REQ-1:0]   x_new,
  input  logic [7*NUM_REQ-1:0]   y_new,
  input  logic [3*NUM_REQ-1:0]   colour_in,
  input  logic [25*NUM_REQ-1:0]  shape_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   busy,
  output logic                   plot_en,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_ACK
  } state_t;

  state_t      r_state;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_win;
  logic [2:0]  r_row;
  logic [2:0]  r_col;
  logic [7:0]  r_xo;
  logic [6:0]  r_yo;
  logic [7:0]  r_xn;
  logic [6:0]  r_yn;
  logic [2:0]  r_colour;
  logic [24:0] r_shape;

  logic          w_found;
  logic [IW-1:0] w_win;
  logic [IW:0]   w_sum;
  logic          w_last_px;
  logic [4:0]    w_pix;

  // Search upward from the slot after the last winner, wrapping once.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_last} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ))
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      if (!w_found && req[w_sum]) begin
        w_found = 1'b1;
        w_win   = w_sum[IW-1:0];
      end
    end
  end

  assign w_last_px = (r_row == 3'd4) && (r_col == 3'd4);
  assign w_pix = {2'b00, r_row} * 5'd5 + {2'b00, r_col};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last   <= IW'(NUM_REQ - 1);
      r_win    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_xo     <= '0;
      r_yo     <= '0;
      r_xn     <= '0;
      r_yn     <= '0;
      r_colour <= '0;
      r_shape  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_row <= '0;
          r_col <= '0;
          if (w_found) begin
            r_win    <= w_win;
            r_last   <= w_win;
            r_xo     <= x_old[8*w_win +: 8];
            r_yo     <= y_old[7*w_win +: 7];
            r_xn     <= x_new[8*w_win +: 8];
            r_yn     <= y_new[7*w_win +: 7];
            r_colour <= colour_in[3*w_win +: 3];
            r_shape  <= shape_in[25*w_win +: 25];
            r_state  <= req_erase[w_win] ? S_ERASE
                                         : S_DRAW;
          end
        end
        S_ERASE, S_DRAW: begin
          if (r_col == 3'd4) begin
            r_col <= '0;
            if (r_row == 3'd4) r_row <= '0;
            else r_row <= r_row + 3'd1;
          end else begin
            r_col <= r_col + 3'd1;
          end
          if (w_last_px)
            r_state <= (r_state == S_ERASE) ? S_DRAW
                                            : S_ACK;
        end
        S_ACK: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);

  always_comb begin
    grant   = '0;
    ack     = '0;
    plot_en = 1'b0;
    x       = '0;
    y       = '0;
    colour  = '0;
    unique case (r_state)
      S_ERASE: begin
        grant[r_win] = 1'b1;
        plot_en = 1'b1;
        x = r_xo + {5'b0, r_col};
        y = r_yo + {4'b0, r_row};
      end
      S_DRAW: begin
        grant[r_win] = 1'b1;
        plot_en = r_shape[w_pix];
        x = r_xn + {5'b0, r_col};
        y = r_yn + {4'b0, r_row};
        colour = r_colour;
      end
      S_ACK: begin
        grant[r_win] = 1'b1;
        ack[r_win]   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Directed bench for sprite_plot_scheduler: single services, wrap,
// round-robin order/spacing, fairness and mid-service reset.
module tb_sprite_plot_scheduler;

  localparam int N = 6;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_erase = '0;
  logic [8*N-1:0] x_old = '0;
  logic [7*N-1:0] y_old = '0;
  logic [8*N-1:0] x_new = '0;
  logic [7*N-1:0] y_new = '0;
  logic [3*N-1:0] colour_in = '0;
  logic [25*N-1:0] shape_in = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           busy;
  logic           plot_en;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;

  int n_chk = 0;
  int n_fail = 0;

  sprite_plot_scheduler #(.NUM_REQ(N)) dut (
    .clock(clock), .reset(reset),
    .req(req), .req_erase(req_erase),
    .x_old(x_old), .y_old(y_old),
    .x_new(x_new), .y_new(y_new),
    .colour_in(colour_in), .shape_in(shape_in),
    .grant(grant), .ack(ack), .busy(busy),
    .plot_en(plot_en), .x(x), .y(y),
    .colour(colour)
  );

  always #5 clock = ~clock;

  task automatic cfg(input int i,
                     input logic [7:0] xo,
                     input logic [6:0] yo,
                     input logic [7:0] xn,
                     input logic [6:0] yn,
                     input logic [2:0] c,
                     input logic [24:0] s,
                     input logic e);
    x_old[8*i +: 8]      = xo;
    y_old[7*i +: 7]      = yo;
    x_new[8*i +: 8]      = xn;
    y_new[7*i +: 7]      = yn;
    colour_in[3*i +: 3]  = c;
    shape_in[25*i +: 25] = s;
    req_erase[i]         = e;
  endtask

  task automatic do_reset();
    @(negedge clock);
    req = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clock);
      if (ack != '0) req = req & ~ack;
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_chk++;
    if ({grant, ack, busy, plot_en, x, y, colour} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0",
               {grant, ack, busy, plot_en, x, y, colour});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_chk++;
      if ({grant, ack, busy, plot_en} !== '0) begin
        n_fail++;
        $display("FAIL idle_quiet: got %h want 0",
                 {grant, ack, busy, plot_en});
      end
    end
  endtask

  task automatic test_erase_draw();
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    logic [N-1:0] eg, ea;
    logic eb, ep;
    bit ok;
    @(negedge clock);
    cfg(0, 8'd10, 7'd20, 8'd11, 7'd20, 3'b110,
        25'h1FFFFFF, 1'b1);
    req = 6'b000001;
    for (int c = 0; c < 52; c++) begin
      @(negedge clock);
      eg = (c <= 50) ? 6'b000001 : 6'b0;
      ea = (c == 50) ? 6'b000001 : 6'b0;
      eb = (c <= 50);
      ep = (c < 50);
      ex = 8'd0; ey = 7'd0; ec = 3'b000;
      if (c < 25) begin
        ex = 8'(10 + c % 5);
        ey = 7'(20 + c / 5);
      end else if (c < 50) begin
        ex = 8'(11 + (c - 25) % 5);
        ey = 7'(20 + (c - 25) / 5);
        ec = 3'b110;
      end
      n_chk++;
      if ({grant, ack, busy, plot_en, x, y, colour} !==
          {eg, ea, eb, ep, ex, ey, ec}) begin
        n_fail++;
        $display("FAIL erase_draw c=%0d: got %h want %h", c,
                 {grant, ack, busy, plot_en, x, y, colour},
                 {eg, ea, eb, ep, ex, ey, ec});
      end
      if (c == 0) begin
        req = '0;
        x_old[7:0] = 8'd99;
        shape_in[24:0] = '0;
      end
    end
    wait_idle(ok);
  endtask

  task automatic test_draw_only();
    int hits;
    bit ok;
    hits = 0;
    @(negedge clock);
    cfg(0, 8'd0, 7'd0, 8'd50, 7'd60, 3'b011,
        25'h0000001, 1'b0);
    req = 6'b000001;
    for (int c = 0; c < 27; c++) begin
      @(negedge clock);
      if (c == 0) req = '0;
      if (plot_en) begin
        hits++;
        n_chk++;
        if ({x, y, colour} !== {8'd50, 7'd60, 3'b011}) begin
          n_fail++;
          $display("FAIL draw_pos: got %h want %h",
                   {x, y, colour}, {8'd50, 7'd60, 3'b011});
        end
      end
      n_chk++;
      if ({grant, ack} !==
          {(c <= 25) ? 6'b000001 : 6'b0,
           (c == 25) ? 6'b000001 : 6'b0}) begin
        n_fail++;
        $display("FAIL draw_only_ga c=%0d: got %h", c,
                 {grant, ack});
      end
    end
    n_chk++;
    if (hits != 1) begin
      n_fail++;
      $display("FAIL draw_hits: got %0d want 1", hits);
    end
    wait_idle(ok);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] order [6];
    int t [6];
    int got;
    logic [N-1:0] pg;
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++)
      cfg(i, 8'(i), 7'(i), 8'(i), 7'(i), 3'b001,
          25'h1FFFFFF, 1'b1);
    req = 6'b111111;
    got = 0;
    pg = '0;
    for (int c = 0; c < 400 && got < 6; c++) begin
      @(negedge clock);
      if (grant != '0 && pg == '0) begin
        order[got] = grant;
        t[got] = c;
        got++;
      end
      if (ack != '0) req = req & ~ack;
      pg = grant;
    end
    n_chk++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL rr_count: got %0d want 6", got);
    end
    for (int k = 0; k < got; k++) begin
      n_chk++;
      if (order[k] !== 6'(1 << k)) begin
        n_fail++;
        $display("FAIL rr_order k=%0d: got %b want %b", k,
                 order[k], 6'(1 << k));
      end
      if (k > 0) begin
        n_chk++;
        if (t[k] - t[k-1] != 52) begin
          n_fail++;
          $display("FAIL rr_spacing k=%0d: got %0d want 52",
                   k, t[k] - t[k-1]);
        end
      end
    end
    wait_idle(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_idle: busy got 1 want 0");
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] seq [4];
    logic [N-1:0] want [4];
    int got;
    logic [N-1:0] pg;
    bit ok;
    want[0] = 6'b000100;
    want[1] = 6'b010000;
    want[2] = 6'b000001;
    want[3] = 6'b000100;
    do_reset();
    for (int i = 0; i < N; i++)
      cfg(i, 8'd0, 7'd0, 8'(40 + i), 7'd5, 3'b010,
          25'h0000001, 1'b0);
    req = 6'b010100;
    got = 0;
    pg = '0;
    for (int c = 0; c < 400 && got < 4; c++) begin
      @(negedge clock);
      if (grant != '0 && pg == '0) begin
        seq[got] = grant;
        got++;
        if (grant == 6'b010000) req[0] = 1'b1;
      end
      if (ack != '0 && ack != 6'b000100)
        req = req & ~ack;
      pg = grant;
    end
    req = '0;
    n_chk++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL fair_count: got %0d want 4", got);
    end
    for (int k = 0; k < got; k++) begin
      n_chk++;
      if (seq[k] !== want[k]) begin
        n_fail++;
        $display("FAIL fair_order k=%0d: got %b want %b", k,
                 seq[k], want[k]);
      end
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    cfg(0, 8'd30, 7'd30, 8'd31, 7'd30, 3'b111,
        25'h1FFFFFF, 1'b1);
    cfg(1, 8'd0, 7'd0, 8'd77, 7'd44, 3'b100,
        25'h1FFFFFF, 1'b0);
    req = 6'b000001;
    for (int c = 0; c < 38; c++) @(negedge clock);
    n_chk++;
    if ({plot_en, x, y} !== {1'b1, 8'd33, 7'd32}) begin
      n_fail++;
      $display("FAIL mid_px12: got %h want %h",
               {plot_en, x, y}, {1'b1, 8'd33, 7'd32});
    end
    reset = 1'b1;
    req = 6'b000010;
    #1;
    n_chk++;
    if ({grant, ack, busy, plot_en, x, y, colour} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outs: got %h want 0",
               {grant, ack, busy, plot_en, x, y, colour});
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      n_chk++;
      if ({ack, busy} !== '0) begin
        n_fail++;
        $display("FAIL mid_no_ack: got %h want 0",
                 {ack, busy});
      end
    end
    reset = 1'b0;
    @(negedge clock);
    n_chk++;
    if ({grant, x, y} !== {6'b000010, 8'd77, 7'd44}) begin
      n_fail++;
      $display("FAIL post_reset_grant: got %h want %h",
               {grant, x, y}, {6'b000010, 8'd77, 7'd44});
    end
    req = '0;
    wait_idle(ok);
  endtask

  task automatic test_wrap();
    logic [7:0] xs [5];
    logic [6:0] ys [5];
    bit ok;
    xs[0] = 8'd254; xs[1] = 8'd255; xs[2] = 8'd0;
    xs[3] = 8'd1;   xs[4] = 8'd2;
    ys[0] = 7'd126; ys[1] = 7'd127; ys[2] = 7'd0;
    ys[3] = 7'd1;   ys[4] = 7'd2;
    @(negedge clock);
    cfg(1, 8'd0, 7'd0, 8'd254, 7'd126, 3'b101,
        25'h1FFFFFF, 1'b0);
    req = 6'b000010;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      if (c == 0) req = '0;
      n_chk++;
      if ({plot_en, x, y, colour} !==
          {1'b1, xs[c % 5], ys[c / 5], 3'b101}) begin
        n_fail++;
        $display("FAIL wrap c=%0d: got %h want %h", c,
                 {plot_en, x, y, colour},
                 {1'b1, xs[c % 5], ys[c / 5], 3'b101});
      end
    end
    wait_idle(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wrap_idle: busy got 1 want 0");
    end
  endtask

  initial begin
    test_reset();
    test_erase_draw();
    test_draw_only();
    test_back_to_back();
    test_fairness();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
